// File: rtl/handshake_rx_capture_if.sv
// Receive-side handshake bundle: transmitter level handshake plus the downstream
// valid/ready word port and the status counters of the capture block.
interface handshake_rx_capture_if #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              t_rdy;
  logic [DATA_W-1:0] t_data;
  logic              r_ack;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_ready;
  logic [CNT_W-1:0]  rx_count;
  logic [15:0]       rx_xfer_cnt;

  // master drives the transmitter levels and the downstream ready
  modport master (
    output t_rdy, t_data, rx_ready,
    input  r_ack, rx_valid, rx_data, rx_count, rx_xfer_cnt
  );

  modport slave (
    input  t_rdy, t_data, rx_ready,
    output r_ack, rx_valid, rx_data, rx_count, rx_xfer_cnt
  );
endinterface

// File: rtl/handshake_rx_capture.sv
// Receive half of a 4-phase handshake: synchronises t_rdy, captures t_data into a
// small FWFT FIFO, returns r_ack and withholds it while the FIFO has no room.
module handshake_rx_capture #(
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic                    rclk,
  input logic                    reset_rclk,
  handshake_rx_capture_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE_R = 2'b00,
    ACK_HI = 2'b01
  } state_t;

  state_t                 state;
  logic                   r_ack_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   t_rdy_s;
  logic [DATA_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count_q;
  logic [15:0]            xfer_q;
  logic                   not_empty;
  logic                   pop;
  logic                   push;

  // Only t_rdy crosses domains; t_data is held stable by the protocol while t_rdy is high.
  always_ff @(posedge rclk or posedge reset_rclk) begin
    if (reset_rclk) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.t_rdy};
    end
  end

  assign t_rdy_s   = sync_q[SYNC_STAGES-1];
  assign not_empty = (count_q != '0);
  assign pop       = not_empty & bus.rx_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push      = (state == IDLE_R) & t_rdy_s & ((count_q < DEPTH_C) | pop);

  always_ff @(posedge rclk or posedge reset_rclk) begin
    if (reset_rclk) begin
      state   <= IDLE_R;
      r_ack_q <= 1'b0;
      xfer_q  <= '0;
    end else begin
      case (state)
        IDLE_R: begin
          if (push) begin
            r_ack_q <= 1'b1;
            xfer_q  <= xfer_q + 16'd1;
            state   <= ACK_HI;
          end else begin
            r_ack_q <= 1'b0;
          end
        end
        ACK_HI: begin
          if (!t_rdy_s) begin
            r_ack_q <= 1'b0;
            state   <= IDLE_R;
          end else begin
            r_ack_q <= 1'b1;
          end
        end
        default: begin
          r_ack_q <= 1'b0;
          state   <= IDLE_R;
        end
      endcase
    end
  end

  always_ff @(posedge rclk) begin
    if (push) begin
      mem[wr_ptr] <= bus.t_data;
    end
  end

  // Occupancy lives in count_q; pointers just wrap and are never compared.
  always_ff @(posedge rclk or posedge reset_rclk) begin
    if (reset_rclk) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.r_ack       = r_ack_q;
  assign bus.rx_valid    = not_empty;
  assign bus.rx_data     = not_empty ? mem[rd_ptr] : '0;
  assign bus.rx_count    = count_q;
  assign bus.rx_xfer_cnt = xfer_q;
endmodule

// File: tb/tb_handshake_rx_capture.sv
// Bench for handshake_rx_capture: directed vector table, hand-written corner
// sequences and a randomized run checked against a queue-based word model.
module tb_handshake_rx_capture;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [31:0] data;
    logic        ready;
    int          exp_count;
    logic [31:0] exp_head;
  } vec_t;

  logic rclk;
  logic reset_rclk;
  int   n_checks;
  int   n_fail;

  handshake_rx_capture_if #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) bus ();

  handshake_rx_capture #(
    .DATA_W(DATA_W),
    .FIFO_DEPTH(DEPTH),
    .SYNC_STAGES(2)
  ) dut (
    .rclk(rclk),
    .reset_rclk(reset_rclk),
    .bus(bus)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // Word-level model: queue of accepted words, total pushes, log of popped words
  logic [31:0] exp_q[$];
  logic [31:0] popped_log[$];
  int          n_push;
  bit          mon_en;
  bit          pop_now;
  logic        ack_pre;
  logic [31:0] data_pre;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_max(input string name, input int act, input int max);
    n_checks++;
    if (act > max) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected at most %0d at %0t", name, act, max, $time);
    end
  endtask

  // Pops are decided by pre-edge values; pushes show up as a rising r_ack after the edge.
  always @(posedge rclk) begin
    if (mon_en) begin
      pop_now  = bus.rx_valid && bus.rx_ready;
      ack_pre  = bus.r_ack;
      data_pre = bus.t_data;
      if (pop_now) begin
        if (exp_q.size() > 0) begin
          check_val("pop_head", bus.rx_data, exp_q[0]);
          popped_log.push_back(bus.rx_data);
          void'(exp_q.pop_front());
        end else begin
          check_val("pop_while_model_empty", bus.rx_valid, 0);
        end
      end
      #1;
      if (mon_en) begin
        if (!ack_pre && bus.r_ack) begin
          check_max("push_room", exp_q.size(), DEPTH - 1);
          exp_q.push_back(data_pre);
          n_push++;
        end
        check_val("mon_count", bus.rx_count, exp_q.size());
        check_val("mon_valid", bus.rx_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check_val("mon_head", bus.rx_data, exp_q[0]);
        check_val("mon_xfer", bus.rx_xfer_cnt, n_push & 32'hFFFF);
      end
    end
  end

  task automatic clear_model();
    exp_q.delete();
    popped_log.delete();
    n_push = 0;
  endtask

  task automatic apply_reset();
    @(negedge rclk);
    mon_en     = 1'b0;
    reset_rclk = 1'b1;
    repeat (2) @(negedge rclk);
    reset_rclk = 1'b0;
    clear_model();
    mon_en = 1'b1;
  endtask

  task automatic wait_ack(input logic lvl, input int budget, input string name, output int edges);
    edges = 0;
    while (bus.r_ack !== lvl && edges < budget) begin
      @(negedge rclk);
      edges++;
    end
    check_val(name, bus.r_ack, lvl);
  endtask

  task automatic apply_stimulus(input logic [31:0] data, input logic ready, input int hold);
    int e;
    int base;
    base         = n_push;
    bus.rx_ready = ready;
    bus.t_data   = data;
    bus.t_rdy    = 1'b1;
    wait_ack(1'b1, 64, "send_ack_high", e);
    repeat (hold) @(negedge rclk);
    bus.t_rdy = 1'b0;
    wait_ack(1'b0, 64, "send_ack_low", e);
    check_val("one_push_per_phase", n_push - base, 1);
  endtask

  task automatic check_output(input string name, input int exp_count, input logic [31:0] exp_head);
    check_val({name, "_count"}, bus.rx_count, exp_count);
    check_val({name, "_valid"}, bus.rx_valid, exp_count != 0);
    if (exp_count != 0) check_val({name, "_head"}, bus.rx_data, exp_head);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t vecs[4];
    int   edges;
    int   low_cycles;
    int   base;
    int   sent;
    int   phase;
    int   gap;

    n_checks     = 0;
    n_fail       = 0;
    mon_en       = 1'b0;
    reset_rclk   = 1'b1;
    bus.t_rdy    = 1'b0;
    bus.t_data   = '0;
    bus.rx_ready = 1'b0;
    clear_model();

    vecs[0] = '{32'h1, 1'b0, 1, 32'h1};
    vecs[1] = '{32'h2, 1'b0, 2, 32'h1};
    vecs[2] = '{32'h3, 1'b0, 3, 32'h1};
    vecs[3] = '{32'h4, 1'b0, 4, 32'h1};

    // Reset values
    apply_reset();
    check_val("reset_r_ack", bus.r_ack, 0);
    check_val("reset_valid", bus.rx_valid, 0);
    check_val("reset_count", bus.rx_count, 0);
    check_val("reset_xfer", bus.rx_xfer_cnt, 0);
    check_val("reset_data", bus.rx_data, 0);

    // Single word and capture latency
    bus.t_data = 32'hDEADBEEF;
    bus.t_rdy  = 1'b1;
    wait_ack(1'b1, 16, "single_ack_high", edges);
    check_max("single_ack_latency", edges, 3);
    check_val("single_valid", bus.rx_valid, 1);
    check_val("single_data", bus.rx_data, 32'hDEADBEEF);
    bus.t_rdy = 1'b0;
    wait_ack(1'b0, 16, "single_ack_low", edges);
    check_max("single_drop_latency", edges, 3);
    bus.rx_ready = 1'b1;
    @(negedge rclk);
    bus.rx_ready = 1'b0;
    check_val("single_popped", bus.rx_valid, 0);

    // Burst into a stalled FIFO from the vector table
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(vecs[i].data, vecs[i].ready, 0);
      check_output("burst", vecs[i].exp_count, vecs[i].exp_head);
    end
    bus.t_data = 32'h5;
    bus.t_rdy  = 1'b1;
    repeat (10) @(negedge rclk);
    check_val("full_no_ack", bus.r_ack, 0);
    check_val("full_count", bus.rx_count, 4);
    check_val("full_xfer", bus.rx_xfer_cnt, 4);
    bus.rx_ready = 1'b1;
    @(negedge rclk);
    bus.rx_ready = 1'b0;
    check_val("full_pop_push_ack", bus.r_ack, 1);
    check_output("full_pop_push", 4, 32'h2);
    bus.t_rdy = 1'b0;
    wait_ack(1'b0, 16, "full_ack_low", edges);

    // Drain everything and check order
    bus.rx_ready = 1'b1;
    repeat (8) @(negedge rclk);
    bus.rx_ready = 1'b0;
    check_val("drain_len", popped_log.size(), 5);
    for (int i = 0; i < 5 && i < popped_log.size(); i++)
      check_val("drain_order", popped_log[i], i + 1);
    check_val("drain_xfer", bus.rx_xfer_cnt, 5);
    check_output("drain_empty", 0, 32'h0);

    // Simultaneous push and pop at count 1
    apply_reset();
    apply_stimulus(32'hA, 1'b0, 0);
    @(negedge rclk);
    bus.t_data = 32'hB;
    bus.t_rdy  = 1'b1;
    repeat (2) @(negedge rclk);
    check_val("simul_pre_ack", bus.r_ack, 0);
    check_output("simul_pre", 1, 32'hA);
    bus.rx_ready = 1'b1;
    @(negedge rclk);
    bus.rx_ready = 1'b0;
    check_val("simul_ack", bus.r_ack, 1);
    check_output("simul_post", 1, 32'hB);
    bus.t_rdy = 1'b0;
    wait_ack(1'b0, 16, "simul_ack_low", edges);

    // Long t_rdy high phase: one push, r_ack held throughout
    base       = n_push;
    bus.t_data = 32'hC;
    bus.t_rdy  = 1'b1;
    wait_ack(1'b1, 16, "long_ack_high", edges);
    low_cycles = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge rclk);
      if (bus.r_ack !== 1'b1) low_cycles++;
    end
    check_val("long_ack_held", low_cycles, 0);
    bus.t_rdy = 1'b0;
    wait_ack(1'b0, 16, "long_ack_low", edges);
    check_val("long_one_push", n_push - base, 1);
    check_output("long", 2, 32'hB);

    // Reset while in ACK_HI with two words queued
    bus.rx_ready = 1'b1;
    @(negedge rclk);
    bus.rx_ready = 1'b0;
    bus.t_data   = 32'h77;
    bus.t_rdy    = 1'b1;
    wait_ack(1'b1, 16, "rst_ack_high", edges);
    check_output("rst_pre", 2, 32'hC);
    @(negedge rclk);
    #2;
    mon_en     = 1'b0;
    reset_rclk = 1'b1;
    #1;
    check_val("rst_async_ack", bus.r_ack, 0);
    check_val("rst_async_count", bus.rx_count, 0);
    check_val("rst_async_valid", bus.rx_valid, 0);
    @(negedge rclk);
    reset_rclk = 1'b0;
    clear_model();
    mon_en = 1'b1;
    wait_ack(1'b1, 16, "rst_recapture", edges);
    check_val("rst_xfer", bus.rx_xfer_cnt, 1);
    check_output("rst_recapture", 1, 32'h77);
    bus.t_rdy = 1'b0;
    wait_ack(1'b0, 16, "rst_ack_low", edges);

    // Randomized traffic with random downstream ready
    base  = n_push;
    sent  = 0;
    phase = 0;
    gap   = 0;
    for (int cyc = 0; cyc < 6000 && sent < 60; cyc++) begin
      @(negedge rclk);
      bus.rx_ready = ($urandom_range(0, 2) != 0);
      case (phase)
        0: begin
          if (gap == 0) begin
            bus.t_data = $urandom;
            bus.t_rdy  = 1'b1;
            gap        = $urandom_range(0, 3);
            phase      = 1;
          end else begin
            gap--;
          end
        end
        1: begin
          if (bus.r_ack) begin
            if (gap == 0) begin
              bus.t_rdy = 1'b0;
              gap       = $urandom_range(0, 3);
              phase     = 2;
            end else begin
              gap--;
            end
          end
        end
        default: begin
          if (!bus.r_ack) begin
            sent++;
            phase = 0;
          end
        end
      endcase
    end
    check_val("rand_all_sent", sent, 60);
    check_val("rand_push_total", n_push - base, 60);
    bus.rx_ready = 1'b1;
    repeat (8) @(negedge rclk);
    bus.rx_ready = 1'b0;
    check_output("rand_drained", 0, 32'h0);
    check_val("rand_xfer", bus.rx_xfer_cnt, 61);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
